axil_req_arbiter: RTL and testbench
===================================

# axil_req_arbiter

Two-requester command arbiter and AXI4-Lite master sequencer feeding the 32-entry × 32-bit AXI4-Lite register slave. Each requester issues single-beat read/write commands on a simple valid/ready port. The block grants one requester at a time and runs the complete AXI4-Lite read or write handshake against the slave. It then returns data and response to the granted requester as a one-cycle pulse. It sits between local control logic (for example a CPU-side bridge and a DMA config engine) and the register slave.

## Interface
- FAIR, default 1: 1 selects round-robin arbitration between requesters; 0 selects fixed priority, where requester 0 always wins a tie.
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester command valid (bit i = requester i)
- req_ready  out  2  per-requester command accept; one-hot or zero
- req_write  in  2  per-requester: 1 = write, 0 = read
- req_addr0, req_addr1  in  [6:2]  word address per requester
- req_wdata0, req_wdata1  in  32  write data per requester
- rsp_valid  out  2  one-cycle completion pulse to the owning requester
- rsp_data  out  32  read data; holds the last read value and is ignored for writes
- rsp_resp  out  2  AXI response code of the completed transaction
- m_awaddr [6:2], m_awvalid out / m_awready in: write address channel
- m_wdata 32, m_wvalid out / m_wready in: write data channel
- m_bresp 2, m_bvalid in / m_bready out: write response channel
- m_araddr [6:2], m_arvalid out / m_arready in: read address channel
- m_rdata 32, m_rresp 2, m_rvalid in / m_rready out: read data channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- **IDLE**
  - Arbitrate among asserted req_valid bits and assert req_ready for the winner only, in the same cycle (combinational from req_valid and the arbiter pointer).
  - On req_valid&req_ready, latch grant id, write flag, address and wdata.
  - Go to WR_REQ or RD_REQ.
- **Round-robin (FAIR=1)**
  - Pointer favours the requester not granted last; reset value favours requester 0.
  - Pointer updates only on command acceptance.
- **WR_REQ**
  - m_awvalid and m_wvalid assert together on entry.
  - Each drops independently on its own handshake. Address and data may complete in either order or in the same cycle.
  - Go to WR_RESP once both handshakes are done.
- **WR_RESP**
  - m_bready=1. On m_bvalid: capture m_bresp into rsp_resp, go to DONE.
- **RD_REQ**
  - m_arvalid=1. On m_arready: go to RD_DATA.
- **RD_DATA**
  - m_rready=1. On m_rvalid: capture m_rdata and m_rresp, go to DONE.
- **DONE**
  - rsp_valid[grant]=1 for exactly one cycle, then IDLE.
  - No back-pressure on responses.
- Request inputs are sampled only at acceptance; later changes have no effect.
- Only one transaction is in flight; no AW/AR overlap.
- m_* valid signals never depend combinationally on m_* ready signals.
- A valid, once raised, holds with stable address and data until its handshake completes.

## Timing
- Reset values: every valid, ready and rsp output is 0; rsp_data=0; rsp_resp=2'b00; state IDLE; pointer → requester 0.
- Reset mid-transaction abandons the transaction with no rsp_valid; the slave is reset by the same reset.
- Write, zero-wait slave: acceptance cycle T; AW/W handshake T+1; B handshake T+2 earliest; rsp_valid T+3.
- Read, zero-wait slave: acceptance T; AR handshake T+1; R handshake T+2 earliest; rsp_valid T+3.
- Back-to-back: the next acceptance happens earliest in the cycle after DONE, so a new transaction every 4 cycles.
- Simultaneous req_valid: exactly one req_ready bit is high; the loser waits in IDLE with its command held.

## Structure
- Package axil_ctrl_pkg:
  - state enum
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - address width constant for [6:2]
- Sub-module rr_arb2: 2-input arbiter with a FAIR parameter.
  - Inputs: request vector, advance strobe.
  - Output: one-hot grant.
  - Holds the priority pointer.

## Test plan
- Reset, then requester 0 writes 0xDEADBEEF to address 5'd3 with zero-wait slave → rsp_valid=2'b01 at T+3, rsp_resp=00; a read of 5'd3 then returns rsp_data=0xDEADBEEF.
- Both requesters valid in the same cycle, FAIR=1, four rounds → grants alternate 0,1,0,1; with FAIR=0 → requester 0 is granted while its req_valid stays high.
- Slave stalls m_wready 3 cycles while m_awready is immediate → m_awvalid drops after 1 cycle; m_wvalid holds 3 cycles with stable wdata; one rsp_valid.
- Slave delays m_rvalid 5 cycles with m_rdata=0x12345678 → m_rready held; rsp_valid=2'b10 one cycle later; rsp_data=0x12345678.
- Reset asserted while in WR_RESP → next cycle all outputs at reset values, no rsp_valid; a fresh write afterwards completes normally.
- Requester changes req_addr the cycle after acceptance (from 5'd7 to 5'd9) → m_awaddr stays 5'd7.

Source files
------------

// File: rtl/axil_ctrl_pkg.sv
// Shared types and constants for the AXI4-Lite command arbiter.
//   state_t      : sequencer states (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE)
//   RESP_*       : AXI response codes
//   ADDR_MSB/LSB : bounds of the word address field [6:2]
//   id2onehot    : requester index to one-hot requester vector
package axil_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ADDR_MSB = 6;
  localparam int ADDR_LSB = 2;

  function automatic logic [1:0] id2onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter.
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_req          : request vector (bit i = requester i)
//   i_advance      : strobe, high when the current grant is consumed
//   o_grant        : one-hot grant (or zero when nothing requests)
// FAIR=1: round robin, pointer favours the requester not granted last.
// FAIR=0: fixed priority, requester 0 wins ties.
module rr_arb2 #(
  parameter bit FAIR = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  // 0 = requester 0 favoured on a tie, 1 = requester 1 favoured.
  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    if (FAIR) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
        default: o_grant = 2'b00;
      endcase
    end else begin
      if (i_req[0])      o_grant = 2'b01;
      else if (i_req[1]) o_grant = 2'b10;
    end
  end

  // Pointer moves only when a grant is actually taken, so a requester that
  // is merely waiting cannot be skipped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= 1'b0;
    end else if (i_advance && FAIR) begin
      r_ptr <= o_grant[0];
    end
  end

endmodule

// File: rtl/axil_req_arbiter.sv
// Two-requester command arbiter and AXI4-Lite master sequencer.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester command handshake (bit i = requester i)
//   req_write             : per-requester 1=write, 0=read
//   req_addr0/1, req_wdata0/1 : per-requester word address and write data
//   rsp_valid             : one-cycle completion pulse to the owning requester
//   rsp_data, rsp_resp    : last read data, response code of completed command
//   m_aw*/m_w*/m_b*/m_ar*/m_r* : AXI4-Lite master channels
//   o_dbg_state           : current sequencer state
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; a raised valid holds with stable payload
// until that transfer, and no valid here depends combinationally on a ready.
module axil_req_arbiter
  import axil_ctrl_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [1:0]               req_write,
  input  logic [ADDR_MSB:ADDR_LSB] req_addr0,
  input  logic [ADDR_MSB:ADDR_LSB] req_addr1,
  input  logic [31:0]              req_wdata0,
  input  logic [31:0]              req_wdata1,
  output logic [1:0]               rsp_valid,
  output logic [31:0]              rsp_data,
  output logic [1:0]               rsp_resp,
  output logic [ADDR_MSB:ADDR_LSB] m_awaddr,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [31:0]              m_wdata,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  input  logic [1:0]               m_bresp,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  output logic [ADDR_MSB:ADDR_LSB] m_araddr,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [31:0]              m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  output state_t                   o_dbg_state
);

  state_t                   r_state, w_next;
  logic [1:0]               w_grant;
  logic                     w_accept;
  logic                     w_sel_id;
  logic                     w_sel_write;
  logic                     r_gnt_id;
  logic [ADDR_MSB:ADDR_LSB] r_addr;
  logic [31:0]              r_wdata;
  logic                     r_aw_pend;
  logic                     r_w_pend;
  logic [31:0]              r_rsp_data;
  logic [1:0]               r_rsp_resp;

  rr_arb2 #(.FAIR(FAIR)) u_arb (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_req     (req_valid),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  assign req_ready   = (r_state == ST_IDLE && !reset) ? w_grant : 2'b00;
  assign w_accept    = |(req_valid & req_ready);
  assign w_sel_id    = w_grant[1];
  assign w_sel_write = w_sel_id ? req_write[1] : req_write[0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = w_sel_write ? ST_WR_REQ : ST_RD_REQ;
      // AW and W finish independently; leave once neither is outstanding.
      ST_WR_REQ:  if ((!r_aw_pend || m_awready) && (!r_w_pend || m_wready))
                    w_next = ST_WR_RESP;
      ST_WR_RESP: if (m_bvalid)  w_next = ST_DONE;
      ST_RD_REQ:  if (m_arready) w_next = ST_RD_DATA;
      ST_RD_DATA: if (m_rvalid)  w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_id   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_aw_pend  <= 1'b0;
      r_w_pend   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_resp <= RESP_OKAY;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_gnt_id  <= w_sel_id;
        r_addr    <= w_sel_id ? req_addr1 : req_addr0;
        r_wdata   <= w_sel_id ? req_wdata1 : req_wdata0;
        r_aw_pend <= w_sel_write;
        r_w_pend  <= w_sel_write;
      end
      if (r_state == ST_WR_REQ) begin
        if (m_awready) r_aw_pend <= 1'b0;
        if (m_wready)  r_w_pend  <= 1'b0;
      end
      if (r_state == ST_WR_RESP && m_bvalid) begin
        r_rsp_resp <= m_bresp;
      end
      if (r_state == ST_RD_DATA && m_rvalid) begin
        r_rsp_data <= m_rdata;
        r_rsp_resp <= m_rresp;
      end
    end
  end

  assign m_awvalid   = (r_state == ST_WR_REQ) && r_aw_pend;
  assign m_wvalid    = (r_state == ST_WR_REQ) && r_w_pend;
  assign m_awaddr    = r_addr;
  assign m_wdata     = r_wdata;
  assign m_bready    = (r_state == ST_WR_RESP);
  assign m_arvalid   = (r_state == ST_RD_REQ);
  assign m_araddr    = r_addr;
  assign m_rready    = (r_state == ST_RD_DATA);
  assign rsp_valid   = (r_state == ST_DONE) ? id2onehot(r_gnt_id) : 2'b00;
  assign rsp_data    = r_rsp_data;
  assign rsp_resp    = r_rsp_resp;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axil_req_arbiter.sv
module tb_axil_req_arbiter;
  import axil_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_resp;
  logic [6:2]  req_addr0, req_addr1, m_awaddr, m_araddr;
  logic [31:0] req_wdata0, req_wdata1, rsp_data, m_wdata, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;
  state_t      dbg_state;

  axil_req_arbiter #(.FAIR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .o_dbg_state(dbg_state)
  );

  // Fixed-priority instance sharing the request inputs, against an
  // always-ready slave.
  logic [1:0]  fp_req_ready, fp_rsp_valid, fp_rsp_resp;
  logic [31:0] fp_rsp_data, fp_m_wdata;
  logic [6:2]  fp_m_awaddr, fp_m_araddr;
  logic        fp_m_awvalid, fp_m_wvalid, fp_m_bready, fp_m_arvalid, fp_m_rready;
  state_t      fp_dbg_state;

  axil_req_arbiter #(.FAIR(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(fp_req_ready), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(fp_rsp_valid), .rsp_data(fp_rsp_data), .rsp_resp(fp_rsp_resp),
    .m_awaddr(fp_m_awaddr), .m_awvalid(fp_m_awvalid), .m_awready(1'b1),
    .m_wdata(fp_m_wdata), .m_wvalid(fp_m_wvalid), .m_wready(1'b1),
    .m_bresp(RESP_OKAY), .m_bvalid(1'b1), .m_bready(fp_m_bready),
    .m_araddr(fp_m_araddr), .m_arvalid(fp_m_arvalid), .m_arready(1'b1),
    .m_rdata(32'h0), .m_rresp(RESP_OKAY), .m_rvalid(1'b1), .m_rready(fp_m_rready),
    .o_dbg_state(fp_dbg_state)
  );

  // ---------------- slave model with programmable waits ----------------
  int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] s_mem [32];
  logic        s_aw_got, s_w_got, s_wr_done, s_ar_got;
  int          s_aw_cnt, s_w_cnt, s_b_cnt, s_ar_cnt, s_r_cnt;
  logic [4:0]  s_aw_addr, s_ar_addr;
  logic [31:0] s_w_data;

  assign m_awready = !s_aw_got && (s_aw_cnt >= cfg_aw);
  assign m_wready  = !s_w_got && (s_w_cnt >= cfg_w);
  assign m_bvalid  = s_aw_got && s_w_got && (s_b_cnt >= cfg_b);
  assign m_bresp   = cfg_bresp;
  assign m_arready = !s_ar_got && (s_ar_cnt >= cfg_ar);
  assign m_rvalid  = s_ar_got && (s_r_cnt >= cfg_r);
  assign m_rdata   = s_mem[s_ar_addr];
  assign m_rresp   = cfg_rresp;

  always @(posedge clk) begin
    if (reset) begin
      s_aw_got <= 0; s_w_got <= 0; s_wr_done <= 0; s_ar_got <= 0;
      s_aw_cnt <= 0; s_w_cnt <= 0; s_b_cnt <= 0; s_ar_cnt <= 0; s_r_cnt <= 0;
      s_aw_addr <= '0; s_ar_addr <= '0; s_w_data <= '0;
      for (int i = 0; i < 32; i++) s_mem[i] <= '0;
    end else begin
      if (m_awvalid && !s_aw_got) begin
        if (m_awready) begin s_aw_got <= 1; s_aw_addr <= m_awaddr; end
        else s_aw_cnt <= s_aw_cnt + 1;
      end
      if (m_wvalid && !s_w_got) begin
        if (m_wready) begin s_w_got <= 1; s_w_data <= m_wdata; end
        else s_w_cnt <= s_w_cnt + 1;
      end
      if (s_aw_got && s_w_got && !s_wr_done) begin
        s_mem[s_aw_addr] <= s_w_data;
        s_wr_done <= 1;
      end
      if (s_aw_got && s_w_got && !m_bvalid) s_b_cnt <= s_b_cnt + 1;
      if (m_bvalid && m_bready) begin
        s_aw_got <= 0; s_w_got <= 0; s_wr_done <= 0;
        s_aw_cnt <= 0; s_w_cnt <= 0; s_b_cnt <= 0;
      end
      if (m_arvalid && !s_ar_got) begin
        if (m_arready) begin s_ar_got <= 1; s_ar_addr <= m_araddr; end
        else s_ar_cnt <= s_ar_cnt + 1;
      end
      if (s_ar_got && !m_rvalid) s_r_cnt <= s_r_cnt + 1;
      if (m_rvalid && m_rready) begin
        s_ar_got <= 0; s_ar_cnt <= 0; s_r_cnt <= 0;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // exp_q entry: {id[66], resp[65:64], data[63:32], cycle[31:0]}
  localparam int EXP_W = 67;
  logic [EXP_W-1:0] exp_q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] ref_last_read;
  logic        ref_ptr;      // 1 = requester 1 favoured on a tie
  int          busy_until;   // last cycle the DUT is occupied
  logic [4:0]  cur_addr;
  logic [31:0] cur_wdata;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] predict(input logic [1:0] pend);
    if (pend == 2'b11) return ref_ptr ? 2'b10 : 2'b01;
    return pend;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    ref_ptr = 1'b0;
    ref_last_read = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    busy_until = cyc - 1;
  endtask

  // ---------------- driver ----------------
  task automatic run_cmds(input logic [1:0] v, input logic [1:0] wr,
                          input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
    logic [1:0]  pend, g;
    logic        id, wrb;
    logic [4:0]  addr;
    logic [31:0] data, rdata;
    logic [1:0]  resp;
    int          lat;
    req_valid = v; req_write = wr;
    req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
    pend = v;
    for (int k = 0; k < 200 && pend != 2'b00; k++) begin
      @(negedge clk);
      if (cyc > busy_until) begin
        g = predict(pend);
        chk("req_ready", 64'(req_ready), 64'(g));
        id   = g[1];
        wrb  = req_write[id];
        addr = id ? req_addr1 : req_addr0;
        data = id ? req_wdata1 : req_wdata0;
        if (wrb) begin
          lat = 3 + max2(cfg_aw, cfg_w) + cfg_b;
          ref_mem[addr] = data;
          rdata = ref_last_read;
          resp  = cfg_bresp;
        end else begin
          lat = 3 + cfg_ar + cfg_r;
          ref_last_read = ref_mem[addr];
          rdata = ref_last_read;
          resp  = cfg_rresp;
        end
        cur_addr = addr; cur_wdata = data;
        exp_q.push_back({id, resp, rdata, 32'(cyc + lat)});
        busy_until = cyc + lat;
        ref_ptr = g[0];
        pend = pend & ~g;
        @(posedge clk); #1;
        // Drop the accepted command and disturb its fields; the DUT must
        // already hold its own copy.
        req_valid[id] = 1'b0;
        req_write[id] = ~req_write[id];
        if (id) begin req_addr1 = req_addr1 + 5'd2; req_wdata1 = $urandom; end
        else    begin req_addr0 = req_addr0 + 5'd2; req_wdata0 = $urandom; end
      end else begin
        chk("req_ready_busy", 64'(req_ready), 64'(0));
      end
    end
    if (pend != 2'b00) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: pending %b never accepted", pend);
      req_valid = 2'b00;
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data",  64'(rsp_data),  64'(0));
    chk("rst_rsp_resp",  64'(rsp_resp),  64'(RESP_OKAY));
    chk("rst_m_valids",  64'({m_awvalid, m_wvalid, m_arvalid}), 64'(0));
    chk("rst_m_readys",  64'({m_bready, m_rready}), 64'(0));
    chk("rst_state",     64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- monitor ----------------
  logic [EXP_W-1:0] mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      while (exp_q.size() != 0 && int'(exp_q[0][31:0]) < cyc) begin
        mon_e = exp_q.pop_front();
        n_checks++; n_fail++;
        $display("FAIL rsp_missing: no rsp_valid by cycle %0d, expected at %0d", cyc, mon_e[31:0]);
      end
      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding", rsp_valid);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(mon_e[66] ? 2'b10 : 2'b01));
          chk("rsp_data",  64'(rsp_data),  64'(mon_e[63:32]));
          chk("rsp_resp",  64'(rsp_resp),  64'(mon_e[65:64]));
          chk("rsp_cycle", 64'(cyc),       64'(mon_e[31:0]));
        end
      end
      if (m_awvalid) chk("m_awaddr", 64'(m_awaddr), 64'(cur_addr));
      if (m_wvalid)  chk("m_wdata",  64'(m_wdata),  64'(cur_wdata));
      if (m_arvalid) chk("m_araddr", 64'(m_araddr), 64'(cur_addr));
      if (m_awvalid && s_aw_got) chk("awvalid_after_hs", 64'(m_awvalid), 64'(0));
      if (m_wvalid && s_w_got)   chk("wvalid_after_hs",  64'(m_wvalid),  64'(0));
      if (m_arvalid && s_ar_got) chk("arvalid_after_hs", 64'(m_arvalid), 64'(0));
      if (m_awvalid || m_arvalid) chk("aw_ar_overlap", 64'({m_awvalid, m_arvalid} == 2'b11), 64'(0));
      if (fp_req_ready != 2'b00)
        chk("fp_grant", 64'(fp_req_ready), 64'(req_valid[0] ? 2'b01 : 2'b10));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] v, wr;
    req_valid = 0; req_write = 0; req_addr0 = 0; req_addr1 = 0;
    req_wdata0 = 0; req_wdata1 = 0;
    cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
    cfg_bresp = RESP_OKAY; cfg_rresp = RESP_OKAY;
    cur_addr = 0; cur_wdata = 0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    busy_until = cyc - 1;
    @(negedge clk);
    check_reset_outs();
    @(posedge clk); #1;

    // Write then read back on requester 0, zero-wait slave.
    run_cmds(2'b01, 2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0); drain();
    run_cmds(2'b01, 2'b00, 5'd3, 5'd0, 32'h0, 32'h0);        drain();

    // Both requesters at once, two rounds (round robin alternation).
    run_cmds(2'b11, 2'b11, 5'd10, 5'd11, 32'h1111_0000, 32'h2222_0000); drain();
    run_cmds(2'b11, 2'b00, 5'd10, 5'd11, 32'h0, 32'h0);                 drain();

    // W channel stalled 3 cycles, AW immediate; address 7 disturbed after accept.
    cfg_w = 3;
    run_cmds(2'b01, 2'b01, 5'd7, 5'd0, 32'hA5A5_5A5A, 32'h0); drain();
    cfg_w = 0;
    run_cmds(2'b01, 2'b00, 5'd7, 5'd0, 32'h0, 32'h0); drain();

    // Read with R delayed 5 cycles on requester 1.
    run_cmds(2'b10, 2'b10, 5'd0, 5'd12, 32'h0, 32'h12345678); drain();
    cfg_r = 5;
    run_cmds(2'b10, 2'b00, 5'd0, 5'd12, 32'h0, 32'h0); drain();
    cfg_r = 0;

    // Reset while waiting in WR_RESP.
    cfg_b = 5;
    run_cmds(2'b01, 2'b01, 5'd4, 5'd0, 32'hCAFE_F00D, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("state_wr_resp", 64'(dbg_state), 64'(ST_WR_RESP));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outs();
    cfg_b = 0;
    @(posedge clk); #1;
    run_cmds(2'b01, 2'b01, 5'd4, 5'd0, 32'h0BAD_BEEF, 32'h0); drain();
    run_cmds(2'b10, 2'b00, 5'd0, 5'd4, 32'h0, 32'h0);         drain();

    // Back-to-back singles, zero wait, no drain in between.
    for (int i = 0; i < 8; i++) begin
      v = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      run_cmds(v, 2'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom);
    end
    drain();

    // Randomized traffic with random waits and responses.
    for (int i = 0; i < 60; i++) begin
      cfg_aw = $urandom_range(0, 3); cfg_w = $urandom_range(0, 3);
      cfg_b  = $urandom_range(0, 3); cfg_ar = $urandom_range(0, 3);
      cfg_r  = $urandom_range(0, 3);
      cfg_bresp = ($urandom_range(0, 1) != 0) ? RESP_SLVERR : RESP_OKAY;
      cfg_rresp = ($urandom_range(0, 1) != 0) ? RESP_SLVERR : RESP_OKAY;
      v  = 2'($urandom_range(1, 3));
      wr = 2'($urandom);
      run_cmds(v, wr, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
